// File: rtl/alu_issue.sv
// alu_issue: issue/sequencing front end for the combinational alu.
// Decodes compact R-type ops, reads a 4-entry register file (r0 == 0),
// drives the alu for one cycle, writes back and returns result + flags.
// One op in flight: IDLE -> EXEC -> RESP -> IDLE.
// Optional: define ALU_ISSUE_SKID_EN to allow accepting the next op in the
// same cycle the current result is retired (RESP -> EXEC, 1 op / 2 cycles).
// Datapath width comes from the global `WIDTH macro (default 8).
`ifndef WIDTH
`define WIDTH 8
`endif

module alu_issue (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       in_instr,
    input  logic [`WIDTH-1:0] in_imm,
    output logic [3:0]        alu_control,
    output logic [`WIDTH-1:0] alu_a,
    output logic [`WIDTH-1:0] alu_b,
    input  logic [`WIDTH-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [`WIDTH-1:0] res_data,
    output logic [1:0]        res_rd,
    output logic              res_carry,
    output logic              res_zero,
    output logic              res_illegal,
    input  logic [1:0]        dbg_sel,
    output logic [`WIDTH-1:0] dbg_data
);
    localparam int W    = `WIDTH;
    localparam int NREG = 4;

    localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010,
                           C_SLL = 4'b0011, C_XOR = 4'b0100, C_SRL = 4'b0101,
                           C_SUB = 4'b0110, C_SRA = 4'b0111, C_SLT = 4'b1000;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                   state_q, state_d;
    logic [NREG-1:0][W-1:0]   regs_q;
    logic [3:0]               ctrl_q;
    logic [W-1:0]             a_q, b_q;
    logic [1:0]               rd_q;
    logic                     ill_q, li_q;
    logic [W-1:0]             rdata_q;
    logic [1:0]               rrd_q;
    logic                     rcarry_q, rzero_q, rill_q;

    logic                     accept;
    logic                     li;
    logic                     f7b5;
    logic [2:0]               funct3;
    logic [1:0]               rd, rs1, rs2;
    logic [3:0]               ctrl_dec;
    logic                     ill_dec;
    logic [W-1:0]             opa, opb;
    logic                     unused_rsvd;

    assign li          = in_instr[11];
    assign f7b5        = in_instr[10];
    assign funct3      = in_instr[9:7];
    assign rd          = in_instr[6:5];
    assign rs1         = in_instr[4:3];
    assign rs2         = in_instr[2:1];
    assign unused_rsvd = in_instr[0];

    // r0 always reads zero regardless of storage contents
    function automatic logic [W-1:0] rf_rd(input logic [NREG-1:0][W-1:0] rf,
                                           input logic [1:0] idx);
        return (idx == 2'd0) ? '0 : rf[idx];
    endfunction

    assign dbg_data = rf_rd(regs_q, dbg_sel);

    // funct3/f7b5 -> alu control code; LI is an ADD of the immediate and zero
    always_comb begin
        ctrl_dec = C_AND;
        ill_dec  = 1'b0;
        if (li) begin
            ctrl_dec = C_ADD;
        end else begin
            case (funct3)
                3'b000:  ctrl_dec = f7b5 ? C_SUB : C_ADD;
                3'b111:  ctrl_dec = C_AND;
                3'b110:  ctrl_dec = C_OR;
                3'b100:  ctrl_dec = C_XOR;
                3'b001:  ctrl_dec = C_SLL;
                3'b101:  ctrl_dec = f7b5 ? C_SRA : C_SRL;
                3'b010:  ctrl_dec = C_SLT;
                default: ill_dec  = 1'b1;
            endcase
        end
        opa = li ? in_imm : rf_rd(regs_q, rs1);
        opb = li ? '0     : rf_rd(regs_q, rs2);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: in_ready = ~rst;
            EXEC: state_d  = RESP;
            RESP: begin
                res_valid = 1'b1;
`ifdef ALU_ISSUE_SKID_EN
                in_ready  = res_ready & ~rst;
`endif
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = in_valid & in_ready;
        if (accept) state_d = EXEC;
    end

    // operand latches at accept; capture + writeback at end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= '0;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            ill_q    <= 1'b0;
            li_q     <= 1'b0;
            rdata_q  <= '0;
            rrd_q    <= '0;
            rcarry_q <= 1'b0;
            rzero_q  <= 1'b0;
            rill_q   <= 1'b0;
        end else begin
            if (accept) begin
                ctrl_q <= ctrl_dec;
                a_q    <= opa;
                b_q    <= opb;
                rd_q   <= rd;
                ill_q  <= ill_dec;
                li_q   <= li;
            end
            if (state_q == EXEC) begin
                rdata_q  <= ill_q ? '0 : alu_out;
                rrd_q    <= rd_q;
                rcarry_q <= (ill_q | li_q) ? 1'b0 : alu_carry;
                rzero_q  <= ill_q ? 1'b0 : alu_zero;
                rill_q   <= ill_q;
                if (!ill_q && rd_q != 2'd0) regs_q[rd_q] <= alu_out;
            end
        end
    end

    assign alu_control = ctrl_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign res_data    = rdata_q;
    assign res_rd      = rrd_q;
    assign res_carry   = rcarry_q;
    assign res_zero    = rzero_q;
    assign res_illegal = rill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural model of the alu attached.
module tb_alu_issue;
    localparam int W = 8;
`ifdef ALU_ISSUE_SKID_EN
    localparam int SPACING = 2;
`else
    localparam int SPACING = 3;
`endif

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, res_valid, res_ready;
    logic [11:0]  in_instr;
    logic [W-1:0] in_imm, alu_a, alu_b, alu_out, res_data, dbg_data;
    logic [3:0]   alu_control;
    logic         alu_carry, alu_zero, res_carry, res_zero, res_illegal;
    logic [1:0]   res_rd, dbg_sel;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_imm(in_imm), .alu_control(alu_control),
        .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_carry(alu_carry),
        .alu_zero(alu_zero), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_rd(res_rd), .res_carry(res_carry),
        .res_zero(res_zero), .res_illegal(res_illegal), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data)
    );

    // external alu: carry is add carry-out / sub borrow, zero on result
    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_control)
            4'b0010: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0110: begin alu_out = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0011: alu_out = alu_a << alu_b[2:0];
            4'b0101: alu_out = alu_a >> alu_b[2:0];
            4'b0111: alu_out = W'($signed(alu_a) >>> alu_b[2:0]);
            4'b1000: alu_out = W'($signed(alu_a) < $signed(alu_b));
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] enc(input logic li, input logic f7,
                                        input logic [2:0] f3, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
        return {li, f7, f3, rd, rs1, rs2, 1'b0};
    endfunction

    task automatic dbg(input string tag, input logic [1:0] sel, input logic [W-1:0] exp);
        @(negedge clk);
        dbg_sel = sel;
        #1 chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    // present an op, wait for accept, then wait for res_valid (bounded)
    task automatic issue(input string tag, input logic [11:0] instr, input logic [W-1:0] imm);
        int w;
        int lat;
        @(negedge clk);
        in_instr  = instr;
        in_imm    = imm;
        in_valid  = 1'b1;
        res_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!res_valid && lat < 20);
        chk({tag, ".latency"}, 32'(lat), 32'd2);
    endtask

    task automatic retire();
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic [11:0] instr, input logic [W-1:0] imm,
                      input logic [W-1:0] e_data, input logic e_c, input logic e_z,
                      input logic e_ill);
        issue(tag, instr, imm);
        chk({tag, ".data"},    32'(res_data),    32'(e_data));
        chk({tag, ".carry"},   32'(res_carry),   32'(e_c));
        chk({tag, ".zero"},    32'(res_zero),    32'(e_z));
        chk({tag, ".illegal"}, 32'(res_illegal), 32'(e_ill));
        chk({tag, ".rd"},      32'(res_rd),      32'(instr[6:5]));
        retire();
    endtask

    initial begin
        int t[3];
        int k;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        in_instr = '0; in_imm = '0; dbg_sel = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.idle_ready", 32'(in_ready), 32'd1);
        chk("rst.res_valid",  32'(res_valid), 32'd0);
        chk("rst.alu_ctrl",   32'(alu_control), 32'd0);
        chk("rst.alu_a",      32'(alu_a), 32'd0);
        chk("rst.res_data",   32'(res_data), 32'd0);
        dbg("rst.r1", 2'd1, 8'h00);

        op("li_r1",   enc(1,0,3'b000,2'd1,2'd0,2'd0), 8'h05, 8'h05, 0, 0, 0);
        op("li_r2",   enc(1,0,3'b000,2'd2,2'd0,2'd0), 8'h03, 8'h03, 0, 0, 0);
        op("add",     enc(0,0,3'b000,2'd3,2'd1,2'd2), 8'h00, 8'h08, 0, 0, 0);
        dbg("dbg.r3_add", 2'd3, 8'h08);
        op("sub_neg", enc(0,1,3'b000,2'd3,2'd2,2'd1), 8'h00, 8'hFE, 1, 0, 0);
        op("sub_z",   enc(0,1,3'b000,2'd3,2'd1,2'd1), 8'h00, 8'h00, 0, 1, 0);
        op("li_80",   enc(1,0,3'b000,2'd1,2'd0,2'd0), 8'h80, 8'h80, 0, 0, 0);
        op("li_03",   enc(1,0,3'b000,2'd2,2'd0,2'd0), 8'h03, 8'h03, 0, 0, 0);
        op("sra",     enc(0,1,3'b101,2'd3,2'd1,2'd2), 8'h00, 8'hF0, 0, 0, 0);
        op("srl",     enc(0,0,3'b101,2'd3,2'd1,2'd2), 8'h00, 8'h10, 0, 0, 0);
        op("sll",     enc(0,0,3'b001,2'd3,2'd1,2'd2), 8'h00, 8'h00, 0, 1, 0);
        op("and",     enc(0,0,3'b111,2'd3,2'd1,2'd2), 8'h00, 8'h00, 0, 1, 0);
        op("or",      enc(0,0,3'b110,2'd3,2'd1,2'd2), 8'h00, 8'h83, 0, 0, 0);
        op("xor",     enc(0,0,3'b100,2'd3,2'd1,2'd2), 8'h00, 8'h83, 0, 0, 0);
        op("slt",     enc(0,0,3'b010,2'd3,2'd1,2'd2), 8'h00, 8'h01, 0, 0, 0);
        op("illegal", enc(0,0,3'b011,2'd3,2'd1,2'd2), 8'h00, 8'h00, 0, 0, 1);
        dbg("dbg.r3_ill", 2'd3, 8'h01);
        op("add_r0",  enc(0,0,3'b000,2'd0,2'd1,2'd2), 8'h00, 8'h83, 0, 0, 0);
        dbg("dbg.r0", 2'd0, 8'h00);

        // result held stable under backpressure
        issue("hold", enc(0,0,3'b000,2'd3,2'd1,2'd2), 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold.valid", 32'(res_valid), 32'd1);
            chk("hold.data",  32'(res_data),  32'h83);
            chk("hold.ready", 32'(in_ready),  32'd0);
        end
        retire();

        // sustained throughput with both sides always willing
        @(negedge clk);
        in_instr = enc(1,0,3'b000,2'd1,2'd0,2'd0);
        in_imm = 8'h11; in_valid = 1'b1; res_ready = 1'b1;
        k = 0; t[0] = 0; t[1] = 0; t[2] = 0;
        for (int i = 0; i < 15; i++) begin
            if (in_ready && k < 3) begin t[k] = i; k++; end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("thru.count", 32'(k), 32'd3);
        chk("thru.gap1",  32'(t[1] - t[0]), 32'(SPACING));
        chk("thru.gap2",  32'(t[2] - t[1]), 32'(SPACING));
        repeat (4) @(negedge clk);
        res_ready = 1'b0;
        dbg("dbg.r1_li", 2'd1, 8'h11);

        // reset while in EXEC drops the op and clears the register file
        @(negedge clk);
        in_instr = enc(1,0,3'b000,2'd2,2'd0,2'd0);
        in_imm = 8'h55; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst.res_valid", 32'(res_valid), 32'd0);
        chk("mrst.in_ready",  32'(in_ready),  32'd0);
        chk("mrst.alu_ctrl",  32'(alu_control), 32'd0);
        dbg_sel = 2'd1;
        #1 chk("mrst.r1", 32'(dbg_data), 32'd0);
        dbg_sel = 2'd2;
        #1 chk("mrst.r2", 32'(dbg_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst.ready_after", 32'(in_ready),  32'd1);
        chk("mrst.valid_after", 32'(res_valid), 32'd0);
        chk("mrst.r2_after",    32'(dbg_data),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // hard stop so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
